// File: rtl/rgmii_rx_frame_decoder.sv
// RGMII receive frame decoder.
// Rebuilds bytes from the captured DDR nibble pairs and strips preamble/SFD.
// Emits a valid/last/error byte stream with a fixed three-cycle input-to-output
// latency. In-band link status is decoded from idle gaps. Saturating good/bad
// frame counters are kept for the switch port logic.
`timescale 1ns/1ps

module rgmii_rx_frame_decoder #(
    parameter bit SWAP_ENABLE   = 1'b0,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               ddr_data_input,
    input  logic [1:0]               ddr_control_input,
    output logic [7:0]               master_data,
    output logic                     master_valid,
    output logic                     master_last,
    output logic                     master_error,
    output logic                     link_up,
    output logic [1:0]               link_speed,
    output logic                     link_full_duplex,
    output logic [COUNTER_WIDTH-1:0] frame_count,
    output logic [COUNTER_WIDTH-1:0] error_count
);

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(
        input logic [COUNTER_WIDTH-1:0] value,
        input logic                     enable
    );
        logic [COUNTER_WIDTH-1:0] result;
        if (enable && (value != CNT_MAX)) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // ---------------------------------------------------------------------
    // Stage 0: capture of the DDR pair
    // ---------------------------------------------------------------------
    logic [7:0] byte_d, byte_q;
    logic       dv_d, dv_q;
    logic       er_d, er_q;

    // Map the nibble pair onto a byte (falling nibble is the high half) and decode DV/ER.
    always_comb begin
        if (SWAP_ENABLE) begin
            byte_d = {ddr_data_input[3:0], ddr_data_input[7:4]};
        end else begin
            byte_d = ddr_data_input;
        end
        dv_d = ddr_control_input[0];
        er_d = ddr_control_input[0] ^ ddr_control_input[1];
    end

    // Stage-0 register: every later decision works from these registered values.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_q <= 8'h00;
            dv_q   <= 1'b0;
            er_q   <= 1'b0;
        end else begin
            byte_q <= byte_d;
            dv_q   <= dv_d;
            er_q   <= er_d;
        end
    end

    // ---------------------------------------------------------------------
    // Frame FSM and one-byte hold register
    // ---------------------------------------------------------------------
    state_t     state_d, state_q;
    logic [7:0] hold_d, hold_q;
    logic       hold_valid_d, hold_valid_q;
    logic       frame_error_d, frame_error_q;
    logic [7:0] out_data_d, out_data_q;
    logic       out_valid_d, out_valid_q;
    logic       out_last_d, out_last_q;
    logic       out_error_d, out_error_q;
    logic       frame_good_s;
    logic       frame_bad_s;

    // The hold register delays each payload byte by one beat. This lets the
    // beat that carries the final byte also be flagged as last when DV drops.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        frame_error_d = frame_error_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        out_last_d    = 1'b0;
        out_error_d   = 1'b0;
        frame_good_s  = 1'b0;
        frame_bad_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hold_valid_d  = 1'b0;
                frame_error_d = 1'b0;
                if (dv_q) begin
                    if (byte_q == PREAMBLE_BYTE) begin
                        state_d = ST_PREAMBLE;
                    end else if (byte_q == SFD_BYTE) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_PREAMBLE: begin
                if (dv_q) begin
                    if (byte_q == PREAMBLE_BYTE) begin
                        state_d = ST_PREAMBLE;
                    end else if (byte_q == SFD_BYTE) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    // Carrier ended before the SFD: an aborted frame.
                    state_d       = ST_IDLE;
                    frame_bad_s   = 1'b1;
                    hold_valid_d  = 1'b0;
                    frame_error_d = 1'b0;
                end
            end

            ST_DATA: begin
                if (dv_q) begin
                    if (hold_valid_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hold_q;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                    hold_d       = byte_q;
                    hold_valid_d = 1'b1;
                    if (er_q) begin
                        frame_error_d = 1'b1;
                    end else begin
                        frame_error_d = frame_error_q;
                    end
                end else begin
                    if (hold_valid_q) begin
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        out_error_d = frame_error_q;
                        out_data_d  = hold_q;
                        if (frame_error_q) begin
                            frame_bad_s = 1'b1;
                        end else begin
                            frame_good_s = 1'b1;
                        end
                    end else begin
                        // SFD followed directly by end of carrier: empty frame.
                        frame_bad_s = 1'b1;
                    end
                    state_d       = ST_IDLE;
                    hold_valid_d  = 1'b0;
                    frame_error_d = 1'b0;
                end
            end

            ST_DROP: begin
                if (dv_q) begin
                    state_d = ST_DROP;
                end else begin
                    state_d       = ST_IDLE;
                    frame_bad_s   = 1'b1;
                    hold_valid_d  = 1'b0;
                    frame_error_d = 1'b0;
                end
            end

            default: begin
                state_d       = ST_IDLE;
                hold_valid_d  = 1'b0;
                frame_error_d = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // In-band link status and counters
    // ---------------------------------------------------------------------
    logic       status_update_s;
    logic       link_up_d, link_up_q;
    logic [1:0] link_speed_d, link_speed_q;
    logic       link_fd_d, link_fd_q;
    logic [COUNTER_WIDTH-1:0] frame_count_d, frame_count_q;
    logic [COUNTER_WIDTH-1:0] error_count_d, error_count_q;

    // Status is taken only from clean idle symbols whose two nibbles agree.
    // False carrier / carrier extend (DV low, ER high) leaves it untouched.
    always_comb begin
        status_update_s = (!dv_q) && (!er_q) && (byte_q[3:0] == byte_q[7:4]);
        if (status_update_s) begin
            link_up_d    = byte_q[0];
            link_speed_d = byte_q[2:1];
            link_fd_d    = byte_q[3];
        end else begin
            link_up_d    = link_up_q;
            link_speed_d = link_speed_q;
            link_fd_d    = link_fd_q;
        end
        frame_count_d = sat_inc(frame_count_q, frame_good_s);
        error_count_d = sat_inc(error_count_q, frame_bad_s);
    end

    // State, datapath, status and counter registers; reset drops any partial frame silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            hold_q        <= 8'h00;
            hold_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            out_data_q    <= 8'h00;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_error_q   <= 1'b0;
            link_up_q     <= 1'b0;
            link_speed_q  <= 2'b00;
            link_fd_q     <= 1'b0;
            frame_count_q <= CNT_ZERO;
            error_count_q <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            frame_error_q <= frame_error_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_error_q   <= out_error_d;
            link_up_q     <= link_up_d;
            link_speed_q  <= link_speed_d;
            link_fd_q     <= link_fd_d;
            frame_count_q <= frame_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign master_data      = out_data_q;
    assign master_valid     = out_valid_q;
    assign master_last      = out_last_q;
    assign master_error     = out_error_q;
    assign link_up          = link_up_q;
    assign link_speed       = link_speed_q;
    assign link_full_duplex = link_fd_q;
    assign frame_count      = frame_count_q;
    assign error_count      = error_count_q;

endmodule

// File: doc/rgmii_rx_frame_decoder.md
Name: rgmii_rx_frame_decoder

Overview:
- Receive-side counterpart of the RGMII DDR transmit path.
- Takes per-cycle DDR pairs (rising/falling nibble and RX_CTL pair) already captured by the input DDR stage, reconstructs bytes, and strips preamble/SFD.
- Emits a byte stream with valid/last/error framing, decodes RGMII in-band link status during inter-frame gaps, and keeps saturating frame and error counters for the switch port logic.

Parameters:
- SWAP_ENABLE, 0, 1 = rising-edge nibble sits in ddr_data_input[7:4] instead of [3:0].
- COUNTER_WIDTH, 16, width of frame_count and error_count.

Ports:
- clock  input  1  receive clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ddr_data_input  input  8  nibble pair; default [3:0] = rising nibble (byte bits 3:0), [7:4] = falling nibble (byte bits 7:4)
- ddr_control_input  input  2  [0] = RX_CTL rising (DV), [1] = RX_CTL falling (DV xor ER)
- master_data  output  8  reconstructed payload byte
- master_valid  output  1  one-cycle qualifier per byte, no backpressure
- master_last  output  1  final byte of frame, only with master_valid
- master_error  output  1  frame had ER or framing fault, only with master_last
- link_up  output  1  in-band link status
- link_speed  output  2  in-band speed, 00 = 10M, 01 = 100M, 10 = 1G
- link_full_duplex  output  1  in-band duplex
- frame_count  output  COUNTER_WIDTH  good frames received
- error_count  output  COUNTER_WIDTH  bad or aborted frames

Behaviour:
- Stage 0 registers the inputs every cycle.
  - byte = {falling, rising} after SWAP_ENABLE mapping.
  - dv = ctl[0], er = ctl[0] xor ctl[1].
- FSM states and transitions (all operating on the stage-0 registers):
  - IDLE, dv=1:
    - byte 0x55 -> PREAMBLE.
    - byte 0xD5 -> DATA (short preamble accepted).
    - else -> DROP.
  - PREAMBLE:
    - dv=1, 0x55 -> stay.
    - dv=1, 0xD5 -> DATA.
    - dv=1, other -> DROP.
    - dv=0 -> IDLE, error_count+1.
  - DATA:
    - dv=1: byte loads the hold register; the previous hold byte (if any) is emitted with master_valid=1, master_last=0.
    - er=1 sets the sticky frame_error flag.
    - dv=0, hold valid: emit hold byte with master_last=1 and master_error=frame_error; frame_count+1 if no error, else error_count+1; -> IDLE.
    - dv=0, hold empty (SFD then end): no output, error_count+1, -> IDLE.
  - DROP:
    - Output stays silent.
    - dv=0 -> IDLE, error_count+1.
- Latency: a byte present on the inputs in cycle c appears on master_data in cycle c+3, fixed. This holds for the last byte too, since the dv-low cycle c+1 triggers its emission.
- Contiguous input gives back-to-back master_valid with no gaps.
- master_valid, master_last and master_error are single-cycle pulses. master_data holds its last value when master_valid=0.
- The frame_error flag and hold-valid flag clear on entry to IDLE.
- In-band status:
  - Updates only when dv=0, er=0 and rising nibble == falling nibble.
  - link_up = nibble[0], link_speed = nibble[2:1], link_full_duplex = nibble[3].
  - dv=0 with er=1 (false carrier or carrier extend) is ignored: no status update, no count.
- Counters saturate at all-ones and never wrap.
- Reset values:
  - All outputs 0, FSM IDLE, hold and flags cleared.
  - Reset mid-frame drops the partial frame silently: no last, no count.
  - If dv is still high after reset, the FSM treats the next byte as a new frame start. A non-preamble byte leads to DROP and one error_count increment.
- Back-to-back frames: a single dv=0 cycle between frames is sufficient. IDLE accepts dv=1 on the cycle after the last-byte emission decision.

Test Plan:
- Frame of 7x0x55, 0xD5, then payload 0x01..0x40 (64 bytes), dv drops -> 64 valid beats, data 0x01..0x40 starting 3 cycles after 0x01 input, last only on 0x40, error=0, frame_count=1.
- Same frame with er=1 on payload byte 10 -> all 64 bytes still emitted, master_error=1 on last beat, error_count=1, frame_count unchanged.
- dv=1 with first byte 0x33 for 20 cycles -> no master_valid, error_count=1. Preamble only, no SFD -> error_count=2. SFD then immediate dv=0 -> error_count=3, no output.
- Gap nibbles dv=0, er=0, data 0xDD (nibble 1101) -> link_up=1, link_speed=10, link_full_duplex=1. Gap data 0xD5 (unequal nibbles) or ctl=2'b10 -> status unchanged.
- SWAP_ENABLE=1 with swapped nibble inputs -> identical byte stream to the first scenario. Preload error_count at all-ones via 65535 bad frames, then one more -> stays 0xFFFF.
- Reset asserted for one cycle mid-payload -> outputs 0 next cycle, no last, counters 0. Remaining dv-high bytes give DROP and error_count=1. The following good frame is received normally.
